// File: rtl/bank_arbiter_pkg.sv
// Shared sizing helpers for the banked memory arbiter and its address decoders.
package bank_arbiter_pkg;

  // Words per bank so that BANKS banks cover the whole address space.
  function automatic int bank_size_f(input int addr_width, input int banks);
    return (((1 << addr_width) - 1) / banks) + 1;
  endfunction

  // Width of a bank-local address.
  function automatic int bank_width_f(input int addr_width, input int banks);
    return $clog2(bank_size_f(addr_width, banks));
  endfunction

endpackage

// File: rtl/decoder.sv
// Splits a global address into a one-hot bank select and a bank-local address.
module decoder
  import bank_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int BANKS      = 3,
  parameter int BANK_SIZE  = bank_size_f(ADDR_WIDTH, BANKS),
  parameter int BANK_WIDTH = bank_width_f(ADDR_WIDTH, BANKS)
) (
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] address_in,
  output logic [BANK_WIDTH-1:0] address_out,
  output logic [BANKS-1:0]      valid_out
);

  // Range compare per bank; exactly one bank matches any address.
  always_comb begin
    valid_out   = '0;
    address_out = '0;
    for (int b = 0; b < BANKS; b++) begin
      if (int'(address_in) >= b * BANK_SIZE && int'(address_in) < (b + 1) * BANK_SIZE) begin
        valid_out[b] = enable;
        address_out  = BANK_WIDTH'(int'(address_in) - b * BANK_SIZE);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting the search at the rotating pointer.
module rr_arbiter #(
  parameter int PORTS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  output logic [PORTS-1:0] grant
);

  localparam int PORT_W = (PORTS > 1) ? $clog2(PORTS) : 1;

  logic [PORT_W-1:0] ptr_reg;
  logic [PORT_W-1:0] ptr_next;
  logic              found;
  int                idx;

  // First requester at or after the pointer (modulo PORTS) wins; pointer moves past it.
  always_comb begin
    grant    = '0;
    ptr_next = ptr_reg;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < PORTS; i++) begin
      idx = (int'(ptr_reg) + i) % PORTS;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_next   = PORT_W'((idx + 1) % PORTS);
      end
    end
  end

  // Pointer holds when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/bank_arbiter.sv
// Multi-port to multi-bank arbiter: per-bank round-robin, registered bank
// command, response returned to the winning port two cycles after acceptance.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter  int ADDR_WIDTH = 4,
  parameter  int BANKS      = 3,
  parameter  int PORTS      = 2,
  parameter  int DATA_WIDTH = 8,
  localparam int BANK_SIZE  = bank_size_f(ADDR_WIDTH, BANKS),
  localparam int BANK_WIDTH = bank_width_f(ADDR_WIDTH, BANKS),
  localparam int PORT_W     = $clog2(PORTS)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            req_valid,
  output logic [PORTS-1:0]            req_ready,
  input  logic [PORTS-1:0]            req_we,
  input  logic [PORTS*ADDR_WIDTH-1:0] req_addr,
  input  logic [PORTS*DATA_WIDTH-1:0] req_wdata,
  output logic [PORTS-1:0]            rsp_valid,
  output logic [PORTS*DATA_WIDTH-1:0] rsp_rdata,
  output logic [BANKS-1:0]            bank_en,
  output logic [BANKS-1:0]            bank_we,
  output logic [BANKS*BANK_WIDTH-1:0] bank_addr,
  output logic [BANKS*DATA_WIDTH-1:0] bank_wdata,
  input  logic [BANKS*DATA_WIDTH-1:0] bank_rdata
);

  localparam int BIDX_W = (BANKS > 1) ? $clog2(BANKS) : 1;

  logic [BANKS-1:0]      hit        [PORTS];
  logic [BANK_WIDTH-1:0] local_addr [PORTS];
  logic [PORTS-1:0]      contend    [BANKS];
  logic [PORTS-1:0]      grant      [BANKS];
  logic                  tag_valid  [BANKS];
  logic [PORT_W-1:0]     tag_port   [BANKS];
  logic                  tag_we     [BANKS];

  // Reset gates the decoder enables, so nothing is granted while rst is high.
  for (genvar gi = 0; gi < PORTS; gi++) begin : g_dec
    decoder #(
      .ADDR_WIDTH(ADDR_WIDTH), .BANKS(BANKS), .BANK_SIZE(BANK_SIZE), .BANK_WIDTH(BANK_WIDTH)
    ) u_dec (
      .enable     (req_valid[gi] & ~rst),
      .address_in (req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH]),
      .address_out(local_addr[gi]),
      .valid_out  (hit[gi])
    );
  end

  // Transpose port-by-bank hits into per-bank contention vectors.
  always_comb begin
    for (int b = 0; b < BANKS; b++)
      for (int p = 0; p < PORTS; p++)
        contend[b][p] = hit[p][b];
  end

  // A port is ready when any bank grants it (it contends for at most one).
  always_comb begin
    req_ready = '0;
    for (int b = 0; b < BANKS; b++)
      req_ready = req_ready | grant[b];
  end

  for (genvar gi = 0; gi < BANKS; gi++) begin : g_bank
    logic [PORT_W-1:0]     win_port;
    logic                  win_any;
    logic                  en_reg, we_reg, tv_reg, tw_reg;
    logic [PORT_W-1:0]     tp_reg;
    logic [BANK_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wdata_reg;

    rr_arbiter #(.PORTS(PORTS)) u_rr (
      .clk(clk), .rst(rst), .req(contend[gi]), .grant(grant[gi])
    );

    // One-hot grant to winner index.
    always_comb begin
      win_port = '0;
      win_any  = 1'b0;
      for (int p = 0; p < PORTS; p++) begin
        if (grant[gi][p]) begin
          win_port = PORT_W'(p);
          win_any  = 1'b1;
        end
      end
    end

    // Command register toward the bank plus the tag used to route the response.
    always_ff @(posedge clk) begin
      if (rst) begin
        en_reg    <= 1'b0;
        we_reg    <= 1'b0;
        addr_reg  <= '0;
        wdata_reg <= '0;
        tv_reg    <= 1'b0;
        tp_reg    <= '0;
        tw_reg    <= 1'b0;
      end else begin
        en_reg <= win_any;
        we_reg <= win_any & req_we[win_port];
        tv_reg <= win_any;
        tp_reg <= win_port;
        tw_reg <= req_we[win_port];
        if (win_any) begin
          addr_reg  <= local_addr[win_port];
          wdata_reg <= req_wdata[int'(win_port)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end

    assign bank_en[gi]                             = en_reg;
    assign bank_we[gi]                             = we_reg;
    assign bank_addr[gi*BANK_WIDTH +: BANK_WIDTH]  = addr_reg;
    assign bank_wdata[gi*DATA_WIDTH +: DATA_WIDTH] = wdata_reg;
    assign tag_valid[gi]                           = tv_reg;
    assign tag_port[gi]                            = tp_reg;
    assign tag_we[gi]                              = tw_reg;
  end

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_rsp
    logic              hit_any, hit_we;
    logic [BIDX_W-1:0] hit_bank;
    logic              rv_reg, rwe_reg;
    logic [BIDX_W-1:0] rbank_reg;

    // Find the bank (if any) whose in-flight command belongs to this port.
    always_comb begin
      hit_any  = 1'b0;
      hit_we   = 1'b0;
      hit_bank = '0;
      for (int b = 0; b < BANKS; b++) begin
        if (tag_valid[b] && tag_port[b] == PORT_W'(gi)) begin
          hit_any  = 1'b1;
          hit_we   = tag_we[b];
          hit_bank = BIDX_W'(b);
        end
      end
    end

    // Response register; read data is steered from the bank as it arrives.
    always_ff @(posedge clk) begin
      if (rst) begin
        rv_reg    <= 1'b0;
        rwe_reg   <= 1'b0;
        rbank_reg <= '0;
      end else begin
        rv_reg    <= hit_any;
        rwe_reg   <= hit_we;
        rbank_reg <= hit_bank;
      end
    end

    assign rsp_valid[gi] = rv_reg;
    assign rsp_rdata[gi*DATA_WIDTH +: DATA_WIDTH] =
      (rv_reg && !rwe_reg) ? bank_rdata[int'(rbank_reg)*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter: bank memories, a global-address reference model and
// directed plus random stimulus.
module tb_bank_arbiter;
  localparam int AW = 4, NB = 3, NP = 2, DW = 8, BS = 6, BW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    req_valid = '0, req_we = '0;
  logic [NP-1:0]    req_ready, rsp_valid;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [NP*DW-1:0] rsp_rdata;
  logic [NB-1:0]    bank_en, bank_we;
  logic [NB*BW-1:0] bank_addr;
  logic [NB*DW-1:0] bank_wdata, bank_rdata;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  bank_arbiter #(.ADDR_WIDTH(AW), .BANKS(NB), .PORTS(NP), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .bank_en(bank_en), .bank_we(bank_we), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata)
  );

  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 7) return 8'hA5;
    return DW'(a * 29 + 51);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // Bank storage: read data appears one cycle after bank_en.
  logic [DW-1:0] bmem [NB][BS];
  logic [DW-1:0] brd  [NB];
  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        brd[b] <= '0;
        for (int l = 0; l < BS; l++) bmem[b][l] <= init_val(b * BS + l);
      end else if (bank_en[b]) begin
        if (bank_we[b]) bmem[b][bank_addr[b*BW +: BW]] <= bank_wdata[b*DW +: DW];
        else            brd[b] <= bmem[b][bank_addr[b*BW +: BW]];
      end
    end
  end
  always_comb for (int b = 0; b < NB; b++) bank_rdata[b*DW +: DW] = brd[b];

  // Reference model over global addresses, checked every falling edge.
  logic [DW-1:0] ref_mem [16];
  int            ptr [NB];
  logic [NB-1:0] c_en = '0;
  logic          c_we [NB];
  int            c_port [NB];
  logic [BW-1:0] c_addr [NB];
  logic [DW-1:0] c_wdata [NB], c_data [NB];
  logic [NP-1:0] r_v = '0;
  logic [DW-1:0] r_data [NP];
  bit            model_on = 0;

  always @(negedge clk) begin
    logic [NP-1:0] g, n_rv;
    logic [NB-1:0] n_en;
    logic          n_we [NB];
    int            n_port [NB], n_glob [NB];
    logic [BW-1:0] n_addr [NB];
    logic [DW-1:0] n_wdata [NB], n_data [NB], n_rdata [NP];
    int            win, p, a;
    g = '0;
    n_en = '0;
    for (int b = 0; b < NB; b++) begin
      win = -1;
      for (int i = 0; i < NP; i++) begin
        p = (ptr[b] + i) % NP;
        a = int'(req_addr[p*AW +: AW]);
        if (win < 0 && !rst && req_valid[p] && a / BS == b) win = p;
      end
      n_port[b] = 0; n_glob[b] = 0; n_we[b] = 0; n_addr[b] = '0; n_wdata[b] = '0; n_data[b] = '0;
      if (win >= 0) begin
        a          = int'(req_addr[win*AW +: AW]);
        g[win]     = 1'b1;
        n_en[b]    = 1'b1;
        n_port[b]  = win;
        n_glob[b]  = a;
        n_we[b]    = req_we[win];
        n_addr[b]  = BW'(a - b * BS);
        n_wdata[b] = req_wdata[win*DW +: DW];
        n_data[b]  = req_we[win] ? '0 : ref_mem[a];
      end
    end
    if (model_on) begin
      check("req_ready", req_ready, g);
      check("bank_en", bank_en, c_en);
      for (int b = 0; b < NB; b++) begin
        if (c_en[b]) begin
          check("bank_we", bank_we[b], c_we[b]);
          check("bank_addr", bank_addr[b*BW +: BW], c_addr[b]);
          check("bank_wdata", bank_wdata[b*DW +: DW], c_wdata[b]);
        end
      end
      check("rsp_valid", rsp_valid, r_v);
      for (int q = 0; q < NP; q++)
        check("rsp_rdata", rsp_rdata[q*DW +: DW], r_v[q] ? r_data[q] : '0);
    end
    for (int b = 0; b < NB; b++)
      if (n_en[b] && n_we[b]) ref_mem[n_glob[b]] = n_wdata[b];
    n_rv = '0;
    for (int q = 0; q < NP; q++) n_rdata[q] = '0;
    for (int b = 0; b < NB; b++) begin
      if (c_en[b] && !rst) begin
        n_rv[c_port[b]]    = 1'b1;
        n_rdata[c_port[b]] = c_data[b];
      end
    end
    if (rst) begin
      for (int b = 0; b < NB; b++) ptr[b] = 0;
      for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
      model_on = 1;
    end else begin
      for (int b = 0; b < NB; b++) if (n_en[b]) ptr[b] = (n_port[b] + 1) % NP;
    end
    c_en = n_en;
    for (int b = 0; b < NB; b++) begin
      c_we[b] = n_we[b]; c_port[b] = n_port[b]; c_addr[b] = n_addr[b];
      c_wdata[b] = n_wdata[b]; c_data[b] = n_data[b];
    end
    r_v = n_rv;
    for (int q = 0; q < NP; q++) r_data[q] = n_rdata[q];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int p, input bit v, input bit we, input int a, input int d);
    req_valid[p] = v;
    req_we[p] = we;
    req_addr[p*AW +: AW] = AW'(a);
    req_wdata[p*DW +: DW] = DW'(d);
  endtask

  initial begin
    int cnt0, cnt1;
    logic [NP-1:0] rdy_last;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Single read of addr 7 (bank 1, local 1)
    drive(0, 1, 0, 7, 0);
    @(negedge clk); check("rd_ready", req_ready, 2'b01);
    tick(); req_valid = '0;
    @(negedge clk); check("rd_bank_en", bank_en, 3'b010); check("rd_bank_addr", bank_addr[5:3], 3'd1);
    tick();
    @(negedge clk); check("rd_rsp_valid", rsp_valid, 2'b01); check("rd_rsp_rdata", rsp_rdata[7:0], 8'hA5);

    // Parallel banks
    tick(); drive(0, 1, 0, 2, 0); drive(1, 1, 0, 15, 0);
    @(negedge clk); check("par_ready", req_ready, 2'b11);
    tick(); req_valid = '0;
    @(negedge clk); check("par_bank_en", bank_en, 3'b101);
    check("par_addr0", bank_addr[2:0], 3'd2); check("par_addr2", bank_addr[8:6], 3'd3);
    tick();
    @(negedge clk); check("par_rsp_valid", rsp_valid, 2'b11);

    // Write ack
    tick(); drive(1, 1, 1, 12, 8'h3C);
    @(negedge clk); check("wr_ready", req_ready, 2'b10);
    tick(); req_valid = '0;
    @(negedge clk); check("wr_bank_we", bank_we, 3'b100);
    check("wr_bank_addr", bank_addr[8:6], 3'd0); check("wr_bank_wdata", bank_wdata[23:16], 8'h3C);
    tick();
    @(negedge clk); check("wr_rsp_valid", rsp_valid, 2'b10); check("wr_rsp_rdata", rsp_rdata[15:8], 8'h00);

    // Contention on bank 0 from reset
    tick(); rst = 1'b1; tick(); rst = 1'b0;
    drive(0, 1, 0, 0, 0); drive(1, 1, 0, 5, 0);
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("cont_grant", req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (req_ready[0]) cnt0++;
      if (req_ready[1]) cnt1++;
      tick();
    end
    check("cont_cnt0", cnt0, 4);
    check("cont_cnt1", cnt1, 4);

    // Reset mid-flight
    req_valid = '0;
    drive(0, 1, 0, 3, 0);
    @(negedge clk); check("rst_acc_ready", req_ready, 2'b01);
    tick(); rst = 1'b1; req_valid = '0;
    @(negedge clk); check("rst_ready_mask", req_ready, 2'b00);
    tick(); rst = 1'b0; drive(0, 1, 0, 0, 0); drive(1, 1, 0, 5, 0);
    @(negedge clk);
    check("rst_rsp_valid", rsp_valid, 2'b00); check("rst_bank_en", bank_en, 3'b000);
    check("rst_bank_we", bank_we, 3'b000); check("rst_rsp_rdata", rsp_rdata, 16'h0);
    check("rst_bank_addr", bank_addr, 9'h0); check("rst_bank_wdata", bank_wdata, 24'h0);
    check("rst_first_win", req_ready, 2'b01);
    tick(); req_valid = '0;

    // Random traffic, requests held until accepted
    rdy_last = '1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] || rdy_last[p])
          drive(p, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 255)));
      end
      @(negedge clk);
      rdy_last = req_ready;
      tick();
    end
    req_valid = '0;
    tick(); tick(); tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
